// File: rtl/seq_alu.sv
// seq_alu: registered WIDTH-bit ALU with a start/busy/done handshake.
// The ALU has 16 ops, including carry-chained ADC/SBB, rotates, an iterative
// shift-add multiply (MUL) and a one-bit-per-cycle variable left shift (SHLN).
// Ports:
//   clk, reset        rising-edge clock, async active-high reset
//   start, opcode     launch request with op select (sampled only in IDLE)
//   a, b              operands, captured with start
//   busy              high while MUL/SHLN iterate
//   done              one-cycle pulse when result/flags are updated
//   result            registered result, held between done pulses
//   zf, cf, nf, of    persistent zero/carry/negative/overflow flags
module seq_alu #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zf,
  output logic             cf,
  output logic             nf,
  output logic             of
);

  localparam int unsigned MSB = WIDTH - 1;
  localparam int unsigned CW  = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MUL, SHIFT} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_cf;
  logic               alu_of;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH-1:0]   shl_next;

  // Single-cycle datapath; the default branch covers SHLN with a zero count
  // (result=a, cf kept) and is don't-care for MUL.
  always_comb begin
    alu_res = a;
    alu_cf  = cf;
    alu_of  = 1'b0;
    sum     = '0;
    case (opcode)
      4'h0: begin alu_res = a & b; alu_cf = 1'b0; end
      4'h1: begin alu_res = a | b; alu_cf = 1'b0; end
      4'h2: begin alu_res = a ^ b; alu_cf = 1'b0; end
      4'h3: begin alu_res = ~a;    alu_cf = 1'b0; end
      4'h4: begin
        sum     = {1'b0, a} + (WIDTH+1)'(1);
        alu_res = sum[WIDTH-1:0];
        alu_cf  = sum[WIDTH];
        alu_of  = ~a[MSB] & alu_res[MSB];
      end
      4'h5: begin
        alu_res = a - WIDTH'(1);
        alu_cf  = (a == '0);
        alu_of  = a[MSB] & ~alu_res[MSB];
      end
      4'h6: begin alu_res = {a[MSB-1:0], 1'b0}; alu_cf = a[MSB]; end
      4'h7: begin alu_res = {1'b0, a[MSB:1]};   alu_cf = a[0];   end
      4'h8, 4'hA: begin
        sum     = {1'b0, a} + {1'b0, b} + (WIDTH+1)'((opcode == 4'hA) & cf);
        alu_res = sum[WIDTH-1:0];
        alu_cf  = sum[WIDTH];
        alu_of  = (a[MSB] == b[MSB]) && (alu_res[MSB] != a[MSB]);
      end
      4'h9, 4'hB: begin
        // Top bit of the (WIDTH+1)-bit difference is the borrow.
        sum     = {1'b0, a} - {1'b0, b} - (WIDTH+1)'((opcode == 4'hB) & cf);
        alu_res = sum[WIDTH-1:0];
        alu_cf  = sum[WIDTH];
        alu_of  = (a[MSB] != b[MSB]) && (alu_res[MSB] != a[MSB]);
      end
      4'hC: begin alu_res = {a[MSB-1:0], a[MSB]}; alu_cf = a[MSB]; end
      4'hD: begin alu_res = {a[0], a[MSB:1]};     alu_cf = a[0];   end
      default: ;
    endcase
  end

  // One shift-add step and one shift step, shared by the iterating states.
  always_comb begin
    mul_next = mplier[0] ? (acc + mcand) : acc;
    shl_next = {acc[MSB-1:0], 1'b0};
  end

  // Control FSM with registered outputs and flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      zf     <= 1'b0;
      cf     <= 1'b0;
      nf     <= 1'b0;
      of     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (opcode == 4'hE) begin
              mcand  <= {{WIDTH{1'b0}}, a};
              mplier <= b;
              acc    <= '0;
              cnt    <= CW'(WIDTH);
              busy   <= 1'b1;
              state  <= MUL;
            end else if (opcode == 4'hF && b[SHW-1:0] != '0) begin
              acc   <= {{WIDTH{1'b0}}, a};
              cnt   <= CW'(b[SHW-1:0]);
              busy  <= 1'b1;
              state <= SHIFT;
            end else begin
              result <= alu_res;
              zf     <= (alu_res == '0);
              nf     <= alu_res[MSB];
              cf     <= alu_cf;
              of     <= alu_of;
              done   <= 1'b1;
            end
          end
        end
        MUL: begin
          acc    <= mul_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            result <= mul_next[WIDTH-1:0];
            zf     <= (mul_next[WIDTH-1:0] == '0);
            nf     <= mul_next[MSB];
            cf     <= |mul_next[2*WIDTH-1:WIDTH];
            of     <= 1'b0;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        SHIFT: begin
          acc <= {{WIDTH{1'b0}}, shl_next};
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            result <= shl_next;
            zf     <= (shl_next == '0);
            nf     <= shl_next[MSB];
            cf     <= acc[MSB];
            of     <= 1'b0;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
